// File: rtl/rv_trap_t.sv
// rv_trap_t: RISC-V machine-mode trap cause codes shared across the core.
// Exception codes go into mcause with bit XLEN-1 clear, interrupt codes with it set.
package rv_trap_t;

    typedef enum logic [5:0] {
        ExcInstMisaligned  = 6'd0,
        ExcInstAccessFault = 6'd1,
        ExcInstIllegal     = 6'd2,
        ExcBreakpoint      = 6'd3,
        ExcLoadMisaligned  = 6'd4,
        ExcLoadFault       = 6'd5,
        ExcStoreMisaligned = 6'd6,
        ExcStoreFault      = 6'd7,
        ExcEcallU          = 6'd8,
        ExcEcallS          = 6'd9,
        ExcEcallM          = 6'd11,
        ExcInstPageFault   = 6'd12,
        ExcLoadPageFault   = 6'd13,
        ExcStorePageFault  = 6'd15
    } exc_cause_e;

    typedef enum logic [5:0] {
        IrqSSoft  = 6'd1,
        IrqMSoft  = 6'd3,
        IrqSTimer = 6'd5,
        IrqMTimer = 6'd7,
        IrqSExt   = 6'd9,
        IrqMExt   = 6'd11
    } irq_cause_e;

endpackage

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: FSM state and CSR-op encodings plus the interrupt priority order
// used by trap_ctrl and trap_irq_prio.
package trap_ctrl_pkg;

    import rv_trap_t::*;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFlush    = 2'd1,
        StRedirect = 2'd2
    } trap_state_e;

    typedef enum logic {
        CsrOpTrap = 1'b0,
        CsrOpMret = 1'b1
    } csr_op_e;

    localparam int unsigned IRQ_PRIO_N = 6;

    // Highest priority first.
    localparam logic [5:0] IRQ_PRIO [IRQ_PRIO_N] = '{
        IrqMExt, IrqMSoft, IrqMTimer, IrqSExt, IrqSSoft, IrqSTimer
    };

endpackage

// File: rtl/trap_irq_prio.sv
// trap_irq_prio: combinational interrupt priority encoder.
//   pending : pending & enabled interrupt vector (IRQ_W bits)
//   valid   : at least one prioritised interrupt is pending
//   code    : cause code of the highest-priority pending interrupt
module trap_irq_prio
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_W = 12
) (
    input  logic [IRQ_W-1:0] pending,
    output logic             valid,
    output logic [5:0]       code
);

    always_comb begin
        valid = 1'b0;
        code  = '0;
        // Walk from lowest to highest priority so the highest pending source wins.
        for (int j = int'(IRQ_PRIO_N) - 1; j >= 0; j--) begin
            for (int b = 0; b < int'(IRQ_W); b++) begin
                if (pending[b] && (6'(b) == IRQ_PRIO[j])) begin
                    valid = 1'b1;
                    code  = IRQ_PRIO[j];
                end
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Accepts an exception, MRET or interrupt
// in IDLE, pulses a CSR update, flushes the pipeline, then redirects fetch.
//   clk, rst            : clock, asynchronous active-low reset
//   i_exc_vld/o_exc_rdy : exception (and MRET) handshake; rdy only in IDLE
//   i_exc_cause/pc/tval : exception details
//   i_mret_vld          : committing MRET
//   i_mip/i_mie/i_mstatus_mie, i_irq_pc_vld/i_irq_pc : interrupt inputs
//   i_mtvec/i_mepc      : current CSR values
//   o_csr_we/o_csr_op, o_mepc/o_mcause/o_mtval : one-cycle CSR update
//   o_flush/i_flush_done                        : pipeline flush
//   o_redirect_vld/o_redirect_pc/i_redirect_rdy : fetch redirect handshake
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned IRQ_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_exc_vld,
    output logic             o_exc_rdy,
    input  logic [5:0]       i_exc_cause,
    input  logic [XLEN-1:0]  i_exc_pc,
    input  logic [XLEN-1:0]  i_exc_tval,
    input  logic             i_mret_vld,
    input  logic [IRQ_W-1:0] i_mip,
    input  logic [IRQ_W-1:0] i_mie,
    input  logic             i_mstatus_mie,
    input  logic             i_irq_pc_vld,
    input  logic [XLEN-1:0]  i_irq_pc,
    input  logic [XLEN-1:0]  i_mtvec,
    input  logic [XLEN-1:0]  i_mepc,
    output logic             o_csr_we,
    output logic             o_csr_op,
    output logic [XLEN-1:0]  o_mepc,
    output logic [XLEN-1:0]  o_mcause,
    output logic [XLEN-1:0]  o_mtval,
    output logic             o_flush,
    input  logic             i_flush_done,
    output logic             o_redirect_vld,
    output logic [XLEN-1:0]  o_redirect_pc,
    input  logic             i_redirect_rdy
);

    trap_state_e     state_q, state_d;
    logic            csr_we_q;
    csr_op_e         op_q, ev_op;
    logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, target_q;
    logic [XLEN-1:0] ev_mepc, ev_mcause, ev_mtval, ev_target;

    logic [IRQ_W-1:0] irq_pend;
    logic             irq_vld;
    logic [5:0]       irq_code;

    logic            idle, take_exc, take_mret, take_irq, accept;
    logic [XLEN-1:0] tvec_base;

    assign irq_pend = i_mip & i_mie;

    trap_irq_prio #(
        .IRQ_W(IRQ_W)
    ) u_irq_prio (
        .pending(irq_pend),
        .valid  (irq_vld),
        .code   (irq_code)
    );

    // Same-cycle priority: exception, then MRET, then interrupt. Losers are not
    // consumed; an interrupt simply stays pending and is re-evaluated in IDLE.
    assign idle      = (state_q == StIdle);
    assign take_exc  = idle & i_exc_vld;
    assign take_mret = idle & ~i_exc_vld & i_mret_vld;
    assign take_irq  = idle & ~i_exc_vld & ~i_mret_vld & irq_vld & i_mstatus_mie & i_irq_pc_vld;
    assign accept    = take_exc | take_mret | take_irq;

    assign tvec_base = {i_mtvec[XLEN-1:2], 2'b00};

    // Event contents captured at acceptance.
    always_comb begin
        ev_op     = CsrOpTrap;
        ev_mepc   = i_exc_pc;
        ev_mcause = XLEN'(i_exc_cause);
        ev_mtval  = i_exc_tval;
        ev_target = tvec_base;
        if (take_mret) begin
            ev_op     = CsrOpMret;
            ev_mepc   = '0;
            ev_mcause = '0;
            ev_mtval  = '0;
            ev_target = i_mepc;
        end else if (take_irq) begin
            ev_mepc             = i_irq_pc;
            ev_mcause           = XLEN'(irq_code);
            ev_mcause[XLEN-1]   = 1'b1;
            ev_mtval            = '0;
            // Vectored mode: base + 4*code, wrapping at 2^XLEN.
            if (i_mtvec[1:0] == 2'b01) begin
                ev_target = tvec_base + XLEN'({irq_code, 2'b00});
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept)         state_d = StFlush;
            // Flush-done during the acceptance cycle is never seen: we are still in IDLE.
            StFlush:    if (i_flush_done)   state_d = StRedirect;
            StRedirect: if (i_redirect_rdy) state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            csr_we_q <= 1'b0;
            op_q     <= CsrOpTrap;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            csr_we_q <= accept;
            if (accept) begin
                op_q     <= ev_op;
                mepc_q   <= ev_mepc;
                mcause_q <= ev_mcause;
                mtval_q  <= ev_mtval;
                target_q <= ev_target;
            end
        end
    end

    assign o_exc_rdy      = idle;
    assign o_csr_we       = csr_we_q;
    assign o_csr_op       = csr_we_q & (op_q == CsrOpMret);
    assign o_mepc         = csr_we_q ? mepc_q : '0;
    assign o_mcause       = csr_we_q ? mcause_q : '0;
    assign o_mtval        = csr_we_q ? mtval_q : '0;
    assign o_flush        = (state_q == StFlush);
    assign o_redirect_vld = (state_q == StRedirect);
    assign o_redirect_pc  = o_redirect_vld ? target_q : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl. The driver pushes the expected CSR
// update / redirect for each accepted event; a monitor pops and compares.
module tb_trap_ctrl;

    localparam int XLEN  = 64;
    localparam int IRQ_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_exc_vld = 1'b0;
    logic             o_exc_rdy;
    logic [5:0]       i_exc_cause = '0;
    logic [XLEN-1:0]  i_exc_pc = '0;
    logic [XLEN-1:0]  i_exc_tval = '0;
    logic             i_mret_vld = 1'b0;
    logic [IRQ_W-1:0] i_mip = '0;
    logic [IRQ_W-1:0] i_mie = '0;
    logic             i_mstatus_mie = 1'b0;
    logic             i_irq_pc_vld = 1'b0;
    logic [XLEN-1:0]  i_irq_pc = '0;
    logic [XLEN-1:0]  i_mtvec = '0;
    logic [XLEN-1:0]  i_mepc = '0;
    logic             o_csr_we;
    logic             o_csr_op;
    logic [XLEN-1:0]  o_mepc, o_mcause, o_mtval;
    logic             o_flush;
    logic             i_flush_done = 1'b0;
    logic             o_redirect_vld;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             i_redirect_rdy = 1'b0;

    trap_ctrl #(
        .XLEN (XLEN),
        .IRQ_W(IRQ_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_exc_vld     (i_exc_vld),
        .o_exc_rdy     (o_exc_rdy),
        .i_exc_cause   (i_exc_cause),
        .i_exc_pc      (i_exc_pc),
        .i_exc_tval    (i_exc_tval),
        .i_mret_vld    (i_mret_vld),
        .i_mip         (i_mip),
        .i_mie         (i_mie),
        .i_mstatus_mie (i_mstatus_mie),
        .i_irq_pc_vld  (i_irq_pc_vld),
        .i_irq_pc      (i_irq_pc),
        .i_mtvec       (i_mtvec),
        .i_mepc        (i_mepc),
        .o_csr_we      (o_csr_we),
        .o_csr_op      (o_csr_op),
        .o_mepc        (o_mepc),
        .o_mcause      (o_mcause),
        .o_mtval       (o_mtval),
        .o_flush       (o_flush),
        .i_flush_done  (i_flush_done),
        .o_redirect_vld(o_redirect_vld),
        .o_redirect_pc (o_redirect_pc),
        .i_redirect_rdy(i_redirect_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] target;
        int          flush_len;
    } exp_t;

    typedef struct {
        logic        exc_vld;
        logic        mret_vld;
        logic [5:0]  cause;
        logic [63:0] exc_pc;
        logic [63:0] tval;
        logic [11:0] mip;
        logic [11:0] mie;
        logic        mstatus_mie;
        logic        irq_pc_vld;
        logic [63:0] irq_pc;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        int          d_f;
        int          d_r;
        bit          fd_acc;
        bit          rst_mid;
    } stim_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cnt = 0;
    int   hs_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, want);
        end
    endtask

    // Reference model: which event wins and what it must produce.
    function automatic exp_t model(input stim_t s, output bit ev);
        exp_t        e;
        int          prio[6] = '{11, 3, 7, 9, 1, 5};
        int          code;
        logic [11:0] pend;
        logic [63:0] base;
        base        = s.mtvec & ~64'h3;
        pend        = s.mip & s.mie;
        e.flush_len = s.d_f + 1;
        e.op        = 1'b0;
        e.mepc      = '0;
        e.mcause    = '0;
        e.mtval     = '0;
        e.target    = '0;
        ev          = 1'b1;
        if (s.exc_vld) begin
            e.mepc   = s.exc_pc;
            e.mcause = 64'(s.cause);
            e.mtval  = s.tval;
            e.target = base;
        end else if (s.mret_vld) begin
            e.op     = 1'b1;
            e.target = s.mepc;
        end else if (pend != 0 && s.mstatus_mie && s.irq_pc_vld) begin
            code = -1;
            for (int k = 0; k < 6; k++) begin
                if (code < 0 && pend[prio[k]]) code = prio[k];
            end
            e.mepc   = s.irq_pc;
            e.mcause = 64'h8000_0000_0000_0000 + 64'(code);
            e.target = base + ((s.mtvec[1:0] == 2'b01) ? 64'(4 * code) : 64'd0);
        end else begin
            ev = 1'b0;
        end
        return e;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.exc_vld = 0; s.mret_vld = 0; s.cause = 0; s.exc_pc = 0; s.tval = 0;
        s.mip = 0; s.mie = 0; s.mstatus_mie = 0; s.irq_pc_vld = 0; s.irq_pc = 0;
        s.mtvec = 0; s.mepc = 0; s.d_f = 0; s.d_r = 0; s.fd_acc = 0; s.rst_mid = 0;
        return s;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_csr_we"}, 64'(o_csr_we), 0);
        chk({tag, "_csr_op"}, 64'(o_csr_op), 0);
        chk({tag, "_mepc"}, o_mepc, 0);
        chk({tag, "_mcause"}, o_mcause, 0);
        chk({tag, "_mtval"}, o_mtval, 0);
        chk({tag, "_flush"}, 64'(o_flush), 0);
        chk({tag, "_redir_vld"}, 64'(o_redirect_vld), 0);
        chk({tag, "_redir_pc"}, o_redirect_pc, 0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic run(input stim_t s);
        exp_t e;
        bit   ev;
        e = model(s, ev);
        chk("rdy_idle", 64'(o_exc_rdy), 1);
        i_exc_vld = s.exc_vld; i_mret_vld = s.mret_vld; i_exc_cause = s.cause;
        i_exc_pc = s.exc_pc; i_exc_tval = s.tval; i_mip = s.mip; i_mie = s.mie;
        i_mstatus_mie = s.mstatus_mie; i_irq_pc_vld = s.irq_pc_vld; i_irq_pc = s.irq_pc;
        i_mtvec = s.mtvec; i_mepc = s.mepc; i_flush_done = s.fd_acc; i_redirect_rdy = 0;
        if (ev) begin
            exp_q.push_back(e);
            if (!s.rst_mid) hs_exp++;
        end
        @(posedge clk); #1;
        i_exc_vld = 0; i_mret_vld = 0; i_flush_done = 0;
        if (!ev) begin
            i_irq_pc_vld = 0;
            @(negedge clk);
            chk("no_event_flush", 64'(o_flush), 0);
            @(posedge clk); #1;
            return;
        end
        // Interrupt inputs stay asserted while busy; they must be ignored.
        repeat (s.d_f) @(posedge clk);
        if (s.d_f > 0) #1;
        i_flush_done = 1;
        @(posedge clk); #1;
        i_flush_done = 0;
        if (s.rst_mid) begin
            #2;
            rst = 0; i_irq_pc_vld = 0; i_mip = 0;
            #1;
            chk_all_zero("rst_redirect");
            @(posedge clk); @(negedge clk);
            rst = 1;
            @(posedge clk); #1;
            chk("rst_rel_rdy", 64'(o_exc_rdy), 1);
            chk("rst_rel_redir", 64'(o_redirect_vld), 0);
            return;
        end
        repeat (s.d_r) @(posedge clk);
        if (s.d_r > 0) #1;
        i_redirect_rdy = 1;
        @(posedge clk); #1;
        i_redirect_rdy = 0; i_irq_pc_vld = 0; i_mip = 0;
    endtask

    // Monitor: pops expectations on each CSR strobe, follows flush and redirect.
    initial begin
        exp_t cur;
        bit   busy = 0;
        bit   saw_redir = 0;
        int   fcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0;
                saw_redir = 0;
            end else begin
                if (o_flush || o_redirect_vld) chk("rdy_busy", 64'(o_exc_rdy), 0);
                if (o_csr_we) begin
                    if (exp_q.size() == 0 || busy) begin
                        chk("unexp_csr_we", 64'(o_csr_we), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        busy = 1; saw_redir = 0; fcnt = 0;
                        chk("csr_op", 64'(o_csr_op), 64'(cur.op));
                        if (!cur.op) begin
                            chk("mepc", o_mepc, cur.mepc);
                            chk("mcause", o_mcause, cur.mcause);
                            chk("mtval", o_mtval, cur.mtval);
                        end
                        chk("flush_at_we", 64'(o_flush), 1);
                    end
                end
                if (o_flush) fcnt++;
                if (o_redirect_vld) begin
                    if (!busy) begin
                        chk("unexp_redirect", 64'(o_redirect_vld), 0);
                    end else begin
                        if (!saw_redir) begin
                            chk("flush_len", 64'(fcnt), 64'(cur.flush_len));
                            saw_redir = 1;
                        end
                        chk("redirect_pc", o_redirect_pc, cur.target);
                        if (i_redirect_rdy) begin
                            hs_cnt++;
                            busy = 0;
                            saw_redir = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        #2;
        chk_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("post_reset_rdy", 64'(o_exc_rdy), 1);

        // Load fault, direct mode.
        s = blank(); s.exc_vld = 1; s.cause = 6'd5; s.exc_pc = 64'h8000_0100;
        s.tval = 64'h1234; s.mtvec = 64'h8000_0000; s.d_f = 1;
        run(s);

        // MExt/MSoft/MTimer pending, vectored: MExt wins, base + 44.
        s = blank(); s.mip = 12'h888; s.mie = 12'h888; s.mstatus_mie = 1; s.irq_pc_vld = 1;
        s.irq_pc = 64'h200; s.mtvec = 64'h8000_0001; s.d_f = 2; s.d_r = 1;
        run(s);

        // Illegal instruction with MTimer pending: exception first, then the timer.
        s = blank(); s.exc_vld = 1; s.cause = 6'd2; s.exc_pc = 64'h8000_0040;
        s.tval = 64'hdead; s.mip = 12'h080; s.mie = 12'h080; s.mstatus_mie = 1;
        s.irq_pc_vld = 1; s.irq_pc = 64'h8000_0044; s.mtvec = 64'h8000_0001; s.d_r = 2;
        run(s);
        s.exc_vld = 0;
        run(s);

        // MRET: flush_done after 5 cycles, redirect_rdy after 3.
        s = blank(); s.mret_vld = 1; s.mepc = 64'h8000_0400; s.mtvec = 64'h8000_0000;
        s.d_f = 5; s.d_r = 3;
        run(s);

        // Flush-done raised in the acceptance cycle must not end the flush.
        s = blank(); s.exc_vld = 1; s.cause = 6'd13; s.exc_pc = 64'h1000;
        s.mtvec = 64'h2003; s.d_f = 2; s.fd_acc = 1;
        run(s);

        // Interrupt masked globally: nothing happens.
        s = blank(); s.mip = 12'h800; s.mie = 12'h800; s.irq_pc_vld = 1;
        run(s);

        // Reset while in REDIRECT.
        s = blank(); s.exc_vld = 1; s.cause = 6'd7; s.exc_pc = 64'h3000;
        s.mtvec = 64'h9000; s.d_f = 1; s.rst_mid = 1;
        run(s);

        // Randomised events.
        for (int n = 0; n < 60; n++) begin
            s = blank();
            s.exc_vld     = ($urandom % 4) == 0;
            s.mret_vld    = ($urandom % 4) == 0;
            s.cause       = 6'($urandom % 16);
            s.exc_pc      = {$urandom, $urandom};
            s.tval        = {$urandom, $urandom};
            s.mip         = 12'($urandom) & 12'hAAA;
            s.mie         = 12'($urandom) & 12'hAAA;
            s.mstatus_mie = ($urandom % 4) != 0;
            s.irq_pc_vld  = ($urandom % 4) != 0;
            s.irq_pc      = {$urandom, $urandom};
            s.mtvec       = {$urandom, $urandom};
            s.mepc        = {$urandom, $urandom};
            s.d_f         = int'($urandom_range(0, 4));
            s.d_r         = int'($urandom_range(0, 3));
            s.fd_acc      = ($urandom % 2) == 1;
            s.rst_mid     = ($urandom % 12) == 0;
            run(s);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 0);
        chk("handshakes", 64'(hs_cnt), 64'(hs_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, integer-register and PC width.
REQ-002 SHALL have parameter IRQ_W, default 12, width of interrupt pending/enable vectors.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_exc_vld  input  1  commit-stage exception request.
REQ-006 SHALL have port o_exc_rdy  output  1  exception accepted when both high.
REQ-007 SHALL have port i_exc_cause  input  6  rv_trap_t::exception code.
REQ-008 SHALL have ports i_exc_pc, i_exc_tval  input  XLEN  faulting PC / trap value.
REQ-009 SHALL have port i_mret_vld  input  1  committing MRET, same handshake as exception via o_exc_rdy.
REQ-010 SHALL have ports i_mip, i_mie  input  IRQ_W  pending / enabled interrupts; i_mstatus_mie input 1 global enable.
REQ-011 SHALL have ports i_irq_pc_vld, i_irq_pc  input 1 / XLEN  precise PC of next instruction to commit.
REQ-012 SHALL have ports i_mtvec, i_mepc  input  XLEN  current CSR values.
REQ-013 SHALL have port o_csr_we  output 1  one-cycle CSR update strobe; o_csr_op output 1 (0 trap-entry, 1 mret).
REQ-014 SHALL have ports o_mepc, o_mcause, o_mtval  output  XLEN  values written when o_csr_we and o_csr_op=0.
REQ-015 SHALL have port o_flush output 1 pipeline flush; i_flush_done input 1 flush complete.
REQ-016 SHALL have ports o_redirect_vld output 1, o_redirect_pc output XLEN, i_redirect_rdy input 1.

Function
REQ-017 SHALL implement FSM IDLE -> FLUSH -> REDIRECT -> IDLE.
REQ-018 o_exc_rdy SHALL equal 1 only in IDLE.
REQ-019 Interrupt taken SHALL = (i_mip & i_mie) nonzero, i_mstatus_mie=1, i_irq_pc_vld=1, in IDLE.
REQ-020 Interrupt priority SHALL be MExt(11) > MSoft(3) > MTimer(7) > SExt(9) > SSoft(1) > STimer(5).
REQ-021 Same-cycle priority SHALL be exception > mret > interrupt; losers not consumed (interrupt re-evaluated later).
REQ-022 On acceptance (cycle N) SHALL latch event; at N+1 assert o_csr_we for exactly one cycle, enter FLUSH.
REQ-023 Exception: o_mepc=i_exc_pc, o_mcause={0,cause zero-extended}, o_mtval=i_exc_tval.
REQ-024 Interrupt: o_mepc=i_irq_pc, o_mcause bit XLEN-1=1 with code in low bits, o_mtval=0.
REQ-025 o_flush SHALL be high throughout FLUSH, from N+1 until the cycle i_flush_done=1 is sampled, inclusive.
REQ-026 Target PC: mret -> i_mepc latched at acceptance; trap -> {i_mtvec[XLEN-1:2],00}; interrupt with i_mtvec[1:0]=01 -> base + 4*code (modulo 2^XLEN).
REQ-027 REDIRECT SHALL hold o_redirect_vld and o_redirect_pc stable until i_redirect_rdy=1, then enter IDLE next cycle.
REQ-028 New events SHALL be ignored outside IDLE; at least one IDLE cycle SHALL separate successive events.
REQ-029 i_flush_done asserted in the same cycle as acceptance SHALL be ignored.

Reset
REQ-030 rst low SHALL immediately force IDLE and zero all outputs except o_exc_rdy, which is 1 once rst is high.
REQ-031 Reset mid-FLUSH/REDIRECT SHALL discard the latched event without CSR write or redirect.

Structure
REQ-032 Shared package SHALL hold FSM state enum, csr-op enum and priority order constant; cause codes SHALL come from package rv_trap_t.
REQ-033 Interrupt priority encoder SHALL be sub-module trap_irq_prio (combinational, IRQ_W in, valid + 6-bit code out).

Verification
REQ-034 Exception loadFault (5), pc=0x8000_0100, tval=0x1234, mtvec=0x8000_0000 -> o_csr_we pulse, mcause=5, mepc=0x8000_0100, mtval=0x1234, redirect 0x8000_0000.
REQ-035 mip=mie=0x888, mstatus_mie=1, mtvec=0x8000_0001, irq_pc=0x200 -> mcause=0x8000_0000_0000_000B, mepc=0x200, redirect 0x8000_002C.
REQ-036 Exception instIllegal (2) and mTimer pending same cycle -> exception taken (mcause=2); after return to IDLE timer taken (mcause MSB=1, code 7).
REQ-037 mret with mepc=0x8000_0400, flush_done delayed 5 cycles, redirect_rdy delayed 3 -> o_flush high 6 cycles, redirect pc 0x8000_0400 held stable, no mepc/mcause/mtval write.
REQ-038 rst asserted during REDIRECT -> outputs 0 asynchronously, no redirect handshake completes, IDLE after release.
